// File: rtl/horizontal_upsample_ctrl_if.sv
// ---------------------------------------------------------------------------
// horizontal_upsample_ctrl_if
//
// Purpose:
//    Bundles the two streaming handshakes of the horizontal chroma upsampler:
//    the input sample stream from the chroma line buffer and the output sample
//    stream to the 4:2:2/4:4:4 output formatter.
//
// Signals:
//    in_valid   upstream -> ctrl   input sample valid
//    in_ready   ctrl -> upstream   input sample accepted when in_valid&in_ready
//    in_data    upstream -> ctrl   8-bit input chroma sample
//    out_valid  ctrl -> downstream output sample valid
//    out_ready  downstream -> ctrl downstream can take a sample
//    out_data   ctrl -> downstream 8-bit output sample
//    out_last   ctrl -> downstream high on the last output beat of a line
//
// Modports:
//    slave   the upsampler controller's view
//    master  the view of whatever drives the input and sinks the output
// ---------------------------------------------------------------------------
interface horizontal_upsample_ctrl_if;

   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_last
   );

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_last
   );

endinterface

// File: rtl/horizontal_upsample_ctrl.sv
// ---------------------------------------------------------------------------
// horizontal_upsample_ctrl
//
// Purpose:
//    Sequencer for the 6-tap horizontal chroma interpolation filter. Takes one
//    line of 8-bit chroma samples, maintains the im3..ip2 tap window with edge
//    replication at both ends of the line, and emits two output samples per
//    input position (interpolated first, then co-sited), so the output line
//    is twice the input width.
//
// Parameters:
//    WIDTH_BITS       width of line_width (max 2^WIDTH_BITS-1 samples/line)
//
// Ports:
//    clk              system clock
//    rst_n            asynchronous active-low reset
//    line_width       input samples per line, latched on the first accept
//    mpeg2_flag       filter mode, latched on the first accept
//    bus              input/output stream handshakes (slave modport)
//    busy             high from first accept until the last output handshake
//    filt_mpeg2_flag  latched mode, to the filter
//    filt_im3..ip2    tap window registers, to the filter
//    filt_out_im1     filter interpolated result
//    filt_out_i       filter co-sited result
// ---------------------------------------------------------------------------
module horizontal_upsample_ctrl #(
   parameter int WIDTH_BITS = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH_BITS-1:0] line_width,
   input  logic                  mpeg2_flag,
   horizontal_upsample_ctrl_if.slave bus,
   output logic                  busy,
   output logic                  filt_mpeg2_flag,
   output logic [7:0]            filt_im3,
   output logic [7:0]            filt_im2,
   output logic [7:0]            filt_im1,
   output logic [7:0]            filt_i,
   output logic [7:0]            filt_ip1,
   output logic [7:0]            filt_ip2,
   input  logic [7:0]            filt_out_im1,
   input  logic [7:0]            filt_out_i
);

   typedef enum logic [2:0] {
      IDLE,
      ACCEPT,
      EMIT0,
      EMIT1,
      FLUSH
   } state_t;

   state_t                state;
   logic [WIDTH_BITS:0]   in_cnt;
   logic [WIDTH_BITS:0]   shift_cnt;
   logic [WIDTH_BITS-1:0] emit_cnt;
   logic [WIDTH_BITS-1:0] width_q;
   logic                  in_ready_q;
   logic                  out_valid_q;
   logic                  out_last_q;

   logic [WIDTH_BITS-1:0] width_eff;
   logic [WIDTH_BITS:0]   in_cnt_inc;
   logic [WIDTH_BITS:0]   shift_cnt_inc;
   logic [WIDTH_BITS-1:0] emit_cnt_inc;
   logic [WIDTH_BITS:0]   width_ext;
   logic                  in_fire;
   logic                  out_fire;
   logic                  last_pair;

   // A zero line width would never terminate, so it is run as a one-sample
   // line instead. The incremented counters are shared by the decisions in
   // the state machine, which look at the post-update values.
   always_comb begin
      width_eff     = (line_width == '0) ? WIDTH_BITS'(1) : line_width;
      in_cnt_inc    = in_cnt + (WIDTH_BITS+1)'(1);
      shift_cnt_inc = shift_cnt + (WIDTH_BITS+1)'(1);
      emit_cnt_inc  = emit_cnt + WIDTH_BITS'(1);
      width_ext     = {1'b0, width_q};
      in_fire       = bus.in_valid & in_ready_q;
      out_fire      = out_valid_q & bus.out_ready;
      last_pair     = (emit_cnt_inc == width_q);
   end

   // Handshake outputs come straight from registers; out_data is picked from
   // the filter results by the emit phase. The taps do not move during
   // EMIT0/EMIT1, so out_data is stable while out_valid is high.
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_data  = (state == EMIT1) ? filt_out_i : filt_out_im1;

   // Line sequencer. The first sample of a line fills the whole window so the
   // left edge is replicated; once all inputs are in, FLUSH shifts in copies
   // of ip2 to replicate the right edge. A pair is emitted after every shift
   // from the second one on, giving width pairs for width+1 shifts.
   // in_ready is held low for the first cycle out of reset because IDLE only
   // raises it on its first clocked visit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         in_cnt          <= '0;
         shift_cnt       <= '0;
         emit_cnt        <= '0;
         width_q         <= '0;
         filt_mpeg2_flag <= 1'b0;
         filt_im3        <= '0;
         filt_im2        <= '0;
         filt_im1        <= '0;
         filt_i          <= '0;
         filt_ip1        <= '0;
         filt_ip2        <= '0;
         in_ready_q      <= 1'b0;
         out_valid_q     <= 1'b0;
         out_last_q      <= 1'b0;
         busy            <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_fire) begin
                  filt_im3        <= bus.in_data;
                  filt_im2        <= bus.in_data;
                  filt_im1        <= bus.in_data;
                  filt_i          <= bus.in_data;
                  filt_ip1        <= bus.in_data;
                  filt_ip2        <= bus.in_data;
                  width_q         <= width_eff;
                  filt_mpeg2_flag <= mpeg2_flag;
                  shift_cnt       <= '0;
                  in_cnt          <= (WIDTH_BITS+1)'(1);
                  emit_cnt        <= '0;
                  busy            <= 1'b1;
                  if (width_eff == WIDTH_BITS'(1)) begin
                     state      <= FLUSH;
                     in_ready_q <= 1'b0;
                  end else begin
                     state      <= ACCEPT;
                     in_ready_q <= 1'b1;
                  end
               end else begin
                  in_ready_q <= 1'b1;
               end
            end

            ACCEPT: begin
               if (in_fire) begin
                  filt_im3  <= filt_im2;
                  filt_im2  <= filt_im1;
                  filt_im1  <= filt_i;
                  filt_i    <= filt_ip1;
                  filt_ip1  <= filt_ip2;
                  filt_ip2  <= bus.in_data;
                  shift_cnt <= shift_cnt_inc;
                  in_cnt    <= in_cnt_inc;
                  if (shift_cnt_inc >= (WIDTH_BITS+1)'(2)) begin
                     state       <= EMIT0;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else if (in_cnt_inc == width_ext) begin
                     state      <= FLUSH;
                     in_ready_q <= 1'b0;
                  end
               end
            end

            FLUSH: begin
               filt_im3    <= filt_im2;
               filt_im2    <= filt_im1;
               filt_im1    <= filt_i;
               filt_i      <= filt_ip1;
               filt_ip1    <= filt_ip2;
               shift_cnt   <= shift_cnt_inc;
               state       <= EMIT0;
               out_valid_q <= 1'b1;
            end

            EMIT0: begin
               if (out_fire) begin
                  state      <= EMIT1;
                  out_last_q <= last_pair;
               end
            end

            EMIT1: begin
               if (out_fire) begin
                  emit_cnt    <= emit_cnt_inc;
                  out_last_q  <= 1'b0;
                  out_valid_q <= 1'b0;
                  if (last_pair) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     in_ready_q <= 1'b1;
                  end else if (in_cnt < width_ext) begin
                     state      <= ACCEPT;
                     in_ready_q <= 1'b1;
                  end else begin
                     state <= FLUSH;
                  end
               end
            end

            default: begin
               state       <= IDLE;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_horizontal_upsample_ctrl.sv
// ---------------------------------------------------------------------------
// tb_horizontal_upsample_ctrl
//
// Purpose:
//    Directed bench for horizontal_upsample_ctrl. A simple stand-in filter
//    produces the co-sited beat as the centre tap and the interpolated beat
//    as the rounded mean of im1 and i, so every expected output is easy to
//    work out by hand.
// ---------------------------------------------------------------------------
module tb_horizontal_upsample_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] line_width;
   logic       mpeg2_flag;
   logic       busy;
   logic       filt_mpeg2_flag;
   logic [7:0] filt_im3, filt_im2, filt_im1, filt_i, filt_ip1, filt_ip2;
   logic [7:0] filt_out_im1, filt_out_i;

   horizontal_upsample_ctrl_if bus ();

   horizontal_upsample_ctrl #(.WIDTH_BITS(10)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .line_width      (line_width),
      .mpeg2_flag      (mpeg2_flag),
      .bus             (bus),
      .busy            (busy),
      .filt_mpeg2_flag (filt_mpeg2_flag),
      .filt_im3        (filt_im3),
      .filt_im2        (filt_im2),
      .filt_im1        (filt_im1),
      .filt_i          (filt_i),
      .filt_ip1        (filt_ip1),
      .filt_ip2        (filt_ip2),
      .filt_out_im1    (filt_out_im1),
      .filt_out_i      (filt_out_i)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Stand-in filter: co-sited = centre tap, interpolated = rounded mean.
   assign filt_out_i   = filt_i;
   assign filt_out_im1 = 8'((9'(filt_im1) + 9'(filt_i) + 9'd1) >> 1);

   logic [7:0]  stim     [0:15];
   logic [7:0]  exp_data [0:31];
   logic [7:0]  got_data [0:31];
   logic        got_last [0:31];
   logic [47:0] got_taps [0:15];
   logic        got_flag [0:15];
   int          stall_beat = -1;
   int          stall_len  = 0;
   int          pass_cnt   = 0;
   int          total_cnt  = 0;

   logic [7:0] ramp40_exp [0:11] = '{8'd0, 8'd0, 8'd20, 8'd40, 8'd60, 8'd80,
                                     8'd100, 8'd120, 8'd140, 8'd160, 8'd180, 8'd200};
   logic [7:0] ramp10_exp [0:15] = '{8'd10, 8'd10, 8'd15, 8'd20, 8'd25, 8'd30,
                                     8'd35, 8'd40, 8'd45, 8'd50, 8'd55, 8'd60,
                                     8'd65, 8'd70, 8'd75, 8'd80};

   // Every comparison goes through here.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total_cnt++;
      if (observed === expected) begin
         pass_cnt++;
      end else begin
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Feed n samples from stim[]. After the first accept the line parameters
   // are scrambled, which the DUT must ignore until the next line.
   task automatic applyStimulus(input int n, input logic [9:0] width, input logic flag);
      int guard;
      line_width = width;
      mpeg2_flag = flag;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = stim[k];
         guard = 0;
         while (!bus.in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 2000) begin
            checkOutput("in_timeout", 64'(guard), 64'd0);
            break;
         end
         @(posedge clk);
         #1;
         if (k == 0) begin
            line_width = width ^ 10'h3;
            mpeg2_flag = ~flag;
         end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // Collect n output beats, stalling out_ready for stall_len cycles when
   // beat stall_beat is presented and checking the stalled beat stays put.
   task automatic collectBeats(input int n);
      int got    = 0;
      int cycles = 0;
      int stall_left = stall_len;
      for (int b = 0; b < 32; b++) got_data[b] = 8'hxx;
      while (got < n && cycles < 2000) begin
         @(negedge clk);
         cycles++;
         if (bus.out_valid && got == stall_beat && stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
            checkOutput("stall_data", 64'(bus.out_data), 64'(exp_data[got]));
            checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
         end else begin
            bus.out_ready = 1'b1;
         end
         if (bus.out_valid && bus.out_ready) begin
            got_data[got] = bus.out_data;
            got_last[got] = bus.out_last;
            if (got % 2 == 0) begin
               got_taps[got/2] = {filt_im3, filt_im2, filt_im1, filt_i, filt_ip1, filt_ip2};
               got_flag[got/2] = filt_mpeg2_flag;
            end
            got++;
         end
      end
      bus.out_ready = 1'b1;
      if (got < n) checkOutput("out_timeout", 64'(got), 64'(n));
   endtask

   // Run one full line of n samples and check every beat, out_last, the
   // latched mode and the return to IDLE.
   task automatic runLine(input int n, input logic flag);
      fork
         applyStimulus(n, 10'(n), flag);
         collectBeats(2 * n);
      join
      for (int b = 0; b < 2 * n; b++) begin
         checkOutput($sformatf("data[%0d]", b), 64'(got_data[b]), 64'(exp_data[b]));
         checkOutput($sformatf("last[%0d]", b), 64'(got_last[b]), 64'(b == 2 * n - 1));
      end
      checkOutput("mode_latched", 64'(got_flag[0]), 64'(flag));
      @(negedge clk);
      checkOutput("idle_busy", 64'(busy), 64'd0);
      checkOutput("idle_in_ready", 64'(bus.in_ready), 64'd1);
   endtask

   // Abort the bench if something hangs outside the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed hang expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      rst_n         = 1'b0;
      line_width    = 10'd0;
      mpeg2_flag    = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'd0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_taps", {16'd0, filt_im3, filt_im2, filt_im1, filt_i, filt_ip1, filt_ip2}, 64'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("rel_in_ready_low", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      checkOutput("rel_in_ready_high", 64'(bus.in_ready), 64'd1);

      $display("[TB] line of eight 100s");
      for (int k = 0; k < 8; k++) stim[k] = 8'd100;
      for (int b = 0; b < 16; b++) exp_data[b] = 8'd100;
      runLine(8, 1'b0);

      $display("[TB] single-sample line");
      stim[0] = 8'd77;
      exp_data[0] = 8'd77;
      exp_data[1] = 8'd77;
      runLine(1, 1'b0);
      checkOutput("w1_taps", 64'(got_taps[0]), 64'h4D4D4D4D4D4D);

      $display("[TB] two-sample line, edge replication");
      stim[0] = 8'd10;
      stim[1] = 8'd20;
      exp_data[0] = 8'd10;
      exp_data[1] = 8'd10;
      exp_data[2] = 8'd15;
      exp_data[3] = 8'd20;
      runLine(2, 1'b0);
      checkOutput("w2_taps0", 64'(got_taps[0]), 64'h0A0A0A0A1414);
      checkOutput("w2_taps1", 64'(got_taps[1]), 64'h0A0A0A141414);

      $display("[TB] mpeg2 ramp line");
      for (int k = 0; k < 6; k++) stim[k] = 8'(40 * k);
      for (int b = 0; b < 12; b++) exp_data[b] = ramp40_exp[b];
      runLine(6, 1'b1);

      $display("[TB] backpressure in EMIT1 of pair 3");
      for (int k = 0; k < 8; k++) stim[k] = 8'(10 * (k + 1));
      for (int b = 0; b < 16; b++) exp_data[b] = ramp10_exp[b];
      stall_beat = 5;
      stall_len  = 5;
      runLine(8, 1'b0);
      stall_beat = -1;
      stall_len  = 0;

      $display("[TB] reset mid-line");
      for (int k = 0; k < 4; k++) stim[k] = 8'd33;
      bus.out_ready = 1'b1;
      applyStimulus(4, 10'd8, 1'b1);
      checkOutput("pre_rst_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("abort_flag", 64'(filt_mpeg2_flag), 64'd0);
      checkOutput("abort_taps", {16'd0, filt_im3, filt_im2, filt_im1, filt_i, filt_ip1, filt_ip2}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rerel_in_ready_low", 64'(bus.in_ready), 64'd0);
      for (int k = 0; k < 3; k++) stim[k] = 8'd50;
      for (int b = 0; b < 6; b++) exp_data[b] = 8'd50;
      runLine(3, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
